key_register_bank: RTL and testbench
====================================

// Module: key_register_bank
// PURPOSE
//   Key storage stage directly downstream of controller. Captures controller's 32-bit out
//   word into the key slot and slice selected by writeEnableKey/sliceSelector.
//   Tracks per-key completeness and streams a complete key, one word per handshake, to the
//   cipher core. Provides per-slot zeroization.
// PARAMETERS
//   NUM_KEYS   6   key slots; equals width of controller writeEnableKey
//   KEY_WORDS  8   32-bit words per key (256-bit key); word index = slice_sel[2:0]
//   DATA_W     32  word width
// PORTS
//   clock          in   1   system clock, rising edge
//   reset_n        in   1   asynchronous, active-low reset
//   wr_data        in   32  key word from controller out
//   slice_sel      in   5   controller sliceSelector; [2:0] word index, [4:3] must be 0
//   wr_en_key      in   6   controller writeEnableKey; one-hot slot select, 0 = no write
//   key_clear      in   6   per-slot zeroize strobe
//   rd_req         in   1   start streaming key rd_key_idx (sampled in IDLE only)
//   rd_key_idx     in   3   slot to stream
//   rd_ready       in   1   consumer accepts rd_data this cycle
//   rd_valid       out  1   rd_data valid
//   rd_data        out  32  key word, word 0 first
//   rd_last        out  1   with rd_valid: final word (index KEY_WORDS-1)
//   rd_err         out  1   1-cycle pulse: rejected request or collision (see below)
//   rd_busy        out  1   FSM not in IDLE
//   wr_err         out  1   1-cycle pulse: illegal write ignored
//   key_valid      out  6   slot k holds all KEY_WORDS words
// BEHAVIOUR
//   Reset (async, reset_n=0): all key words 0, word masks 0, key_valid=0, FSM IDLE,
//     rd_valid=rd_last=rd_err=rd_busy=wr_err=0, rd_data=0. Outputs are registered.
//   Write: on clock edge with wr_en_key one-hot and slice_sel[4:3]==0:
//     slot[k].word[slice_sel[2:0]] <= wr_data; mask[k][idx] <= 1.
//     key_valid[k] = &mask[k]; it rises the cycle after the last missing word is written.
//   Illegal write (wr_en_key not one-hot and !=0, or slice_sel[4:3]!=0): no state change;
//     wr_err pulses next cycle. Overwrite of an already written word is legal.
//   key_clear[k]: slot k words and mask <= 0 next edge. Clear beats write on same slot
//     in the same cycle (no wr_err).
//   FSM IDLE -> STREAM: rd_req=1 in IDLE, rd_key_idx<NUM_KEYS, key_valid[idx]=1.
//     Next cycle rd_valid=1, rd_data=word0, rd_busy=1.
//   Rejected request (idx>=NUM_KEYS or key invalid): stays IDLE; rd_err pulses next cycle.
//   STREAM: word advances only on rd_valid&rd_ready; rd_data held stable while stalled.
//     rd_last=1 with word KEY_WORDS-1. On its handshake: rd_valid=0 and FSM IDLE next cycle.
//     A new rd_req is accepted in that IDLE cycle at the earliest.
//     Minimum latency: rd_req -> word0 = 1 cycle; full key = KEY_WORDS cycles at rd_ready=1.
//   rd_req while STREAM: ignored, no rd_err.
//   Collision: write or clear to the streamed slot during STREAM sets a sticky flag.
//     rd_data reflects live register contents. Stream completes normally; rd_err pulses on
//     the cycle of the rd_last handshake. Flag cleared on return to IDLE.
//   reset_n low mid-stream: immediate abort to reset state; no rd_last.
// STRUCTURE
//   crypto_defs.vh: NUM_KEYS, KEY_WORDS, DATA_W, FSM state encodings (ST_IDLE, ST_STREAM).
//   Sub-module key_slot (one per slot via generate): KEY_WORDS x DATA_W regs + word mask,
//     write/clear ports, key_valid output, combinational word-read mux.
//   Top: write decode/legality check, read FSM with word counter, collision flag, output regs.
// TESTING
//   1 Fill slot 0 with words 0x11111111..0x88888888 (slice 0..7) -> key_valid=6'b000001
//     one cycle after the 8th write.
//   2 rd_req idx 0, rd_ready=1 -> words 0x11111111..0x88888888 on 8 consecutive cycles;
//     rd_last on 8th; rd_busy low after.
//   3 Same stream with rd_ready low on cycles 3-5 -> rd_data held at word 2; order intact;
//     total 11 cycles.
//   4 wr_en_key=6'b000011 or slice_sel=5'b01000 -> wr_err pulse, storage unchanged;
//     rd_req idx 7 or invalid slot 2 -> rd_err pulse, rd_valid stays 0.
//   5 Write slot0 word5=0xDEADBEEF during stream of slot 0 before word5 -> word5 streams
//     0xDEADBEEF; rd_err pulses with rd_last.
//   6 key_clear[0] and write to slot0 same cycle -> slot cleared, key_valid[0]=0;
//     reset_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/key_register_bank_pkg.sv
// Shared sizing, read-FSM encoding and the write-select legality helper for the key bank.
package key_register_bank_pkg;
  localparam int NUM_KEYS  = 6;
  localparam int KEY_WORDS = 8;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = $clog2(KEY_WORDS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction
endpackage

// File: rtl/key_register_bank_key_slot.sv
// One key slot: KEY_WORDS data registers, a written-word mask and an unregistered word mux.
module key_slot
  import key_register_bank_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic              i_clr,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_key_valid
);
  logic [KEY_WORDS-1:0][DATA_W-1:0] r_words;
  logic [KEY_WORDS-1:0]             r_mask;

  // Zeroize has priority over a same-cycle write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_words <= '0;
      r_mask  <= '0;
    end else if (i_clr) begin
      r_words <= '0;
      r_mask  <= '0;
    end else if (i_we) begin
      r_words[i_widx] <= i_wdata;
      r_mask[i_widx]  <= 1'b1;
    end
  end

  assign o_rdata     = r_words[i_ridx];
  assign o_key_valid = &r_mask;
endmodule

// File: rtl/key_register_bank.sv
// Key storage bank: decodes controller writes into slots and streams a complete key
// word by word to the cipher core over a valid/ready handshake.
module key_register_bank
  import key_register_bank_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [4:0]          slice_sel,
  input  logic [NUM_KEYS-1:0] wr_en_key,
  input  logic [NUM_KEYS-1:0] key_clear,
  input  logic                rd_req,
  input  logic [2:0]          rd_key_idx,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rd_err,
  output logic                rd_busy,
  output logic                wr_err,
  output logic [NUM_KEYS-1:0] key_valid
);
  logic                             w_wr_any, w_wr_bad, w_wr_ok;
  logic [NUM_KEYS-1:0]              w_slot_we;
  logic [NUM_KEYS-1:0][DATA_W-1:0]  w_slot_word;
  logic                             w_req_ok, w_hs, w_coll_evt;

  rd_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_kidx, w_kidx_nxt;
  logic             r_coll, w_coll_nxt;
  logic             r_rd_err, w_rd_err_nxt;
  logic             r_wr_err;

  assign w_wr_any  = |wr_en_key;
  assign w_wr_bad  = w_wr_any && (!is_onehot(wr_en_key) || (slice_sel[4:3] != 2'b00));
  assign w_wr_ok   = w_wr_any && !w_wr_bad;
  assign w_slot_we = w_wr_ok ? (wr_en_key & ~key_clear) : '0;

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_slot
      key_slot u_slot (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_we        (w_slot_we[k]),
        .i_clr       (key_clear[k]),
        .i_widx      (slice_sel[IDX_W-1:0]),
        .i_wdata     (wr_data),
        .i_ridx      (r_cnt),
        .o_rdata     (w_slot_word[k]),
        .o_key_valid (key_valid[k])
      );
    end
  endgenerate

  assign w_req_ok   = (rd_key_idx < 3'(NUM_KEYS)) && key_valid[rd_key_idx];
  assign w_hs       = rd_valid && rd_ready;
  assign w_coll_evt = w_slot_we[r_kidx] | key_clear[r_kidx];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_kidx_nxt   = r_kidx;
    w_coll_nxt   = r_coll;
    w_rd_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_req) begin
          if (w_req_ok) begin
            w_state_nxt = ST_STREAM;
            w_cnt_nxt   = '0;
            w_kidx_nxt  = rd_key_idx;
            w_coll_nxt  = 1'b0;
          end else begin
            w_rd_err_nxt = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (w_coll_evt) w_coll_nxt = 1'b1;
        if (w_hs) begin
          if (rd_last) begin
            w_state_nxt = ST_IDLE;
            w_coll_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_kidx   <= '0;
      r_coll   <= 1'b0;
      r_rd_err <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_kidx   <= w_kidx_nxt;
      r_coll   <= w_coll_nxt;
      r_rd_err <= w_rd_err_nxt;
      r_wr_err <= w_wr_bad;
    end
  end

  // rd_data tracks live storage so an in-flight overwrite shows up in the stream.
  assign rd_valid = (r_state == ST_STREAM);
  assign rd_busy  = (r_state == ST_STREAM);
  assign rd_last  = rd_valid && (r_cnt == IDX_W'(KEY_WORDS - 1));
  assign rd_data  = rd_valid ? w_slot_word[r_kidx] : '0;
  // Collision error lands on the cycle of the final handshake itself.
  assign rd_err   = r_rd_err | (r_coll & rd_last & rd_ready);
  assign wr_err   = r_wr_err;
endmodule

// File: tb/tb_key_register_bank.sv
// Directed bench for key_register_bank: expected stream words queued at request time,
// popped and compared on each observed handshake.
module tb_key_register_bank;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] wr_data;
  logic [4:0]  slice_sel;
  logic [5:0]  wr_en_key, key_clear;
  logic        rd_req;
  logic [2:0]  rd_key_idx;
  logic        rd_ready;
  logic        rd_valid, rd_last, rd_err, rd_busy, wr_err;
  logic [31:0] rd_data;
  logic [5:0]  key_valid;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] exp_q[$];

  key_register_bank dut (
    .clock(clock), .reset_n(reset_n), .wr_data(wr_data), .slice_sel(slice_sel),
    .wr_en_key(wr_en_key), .key_clear(key_clear), .rd_req(rd_req), .rd_key_idx(rd_key_idx),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_err(rd_err), .rd_busy(rd_busy), .wr_err(wr_err), .key_valid(key_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int slot, input int idx, input logic [31:0] d);
    wr_en_key = 6'(1 << slot);
    slice_sel = 5'(idx);
    wr_data   = d;
    step();
    wr_en_key = '0;
    slice_sel = '0;
  endtask

  // Streams slot idx; stall bit c drops rd_ready on cycle c; optional write at inj_cyc.
  task automatic run_stream(input int idx, input logic [31:0] stall, input logic exp_err,
                            input int exp_cycles, input int inj_cyc, input int inj_word,
                            input logic [31:0] inj_data);
    int cyc = 0;
    logic [31:0] w;
    rd_req = 1'b1; rd_key_idx = 3'(idx); rd_ready = 1'b1;
    step();
    rd_req = 1'b0;
    while (exp_q.size() > 0 && cyc < 40) begin
      cyc++;
      rd_ready = !stall[cyc];
      if (cyc == inj_cyc) begin
        wr_en_key = 6'(1 << idx); slice_sel = 5'(inj_word); wr_data = inj_data;
      end else begin
        wr_en_key = '0; slice_sel = '0;
      end
      @(negedge clock);
      if (rd_valid && rd_ready) begin
        w = exp_q.pop_front();
        chk("rd_data", rd_data, w);
        chk("rd_last", rd_last, exp_q.size() == 0);
        chk("rd_err_stream", rd_err, (exp_q.size() == 0) ? exp_err : 1'b0);
      end
      step();
    end
    exp_q.delete();
    wr_en_key = '0;
    rd_ready  = 1'b0;
    chk("stream_cycles", cyc, exp_cycles);
    chk("busy_after", rd_busy, 1'b0);
    chk("valid_after", rd_valid, 1'b0);
    chk("rd_err_after", rd_err, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; wr_data = '0; slice_sel = '0; wr_en_key = '0; key_clear = '0;
    rd_req = 1'b0; rd_key_idx = '0; rd_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_rd_err", rd_err, 0);
    reset_n = 1'b1;
    step();

    // fill slot 0; key_valid rises only after the 8th word
    for (int i = 0; i < 8; i++) begin
      wr(0, i, 32'h11111111 * (i + 1));
      if (i == 6) chk("kv_before_last", key_valid, 6'b000000);
    end
    chk("kv_after_fill", key_valid, 6'b000001);

    // full-rate stream, then the same stream stalled on cycles 3-5
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h11111111 * (i + 1));
    run_stream(0, 32'h0, 1'b0, 8, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h11111111 * (i + 1));
    run_stream(0, 32'h38, 1'b0, 11, 0, 0, 32'h0);

    // illegal writes: two-hot enable, nonzero slice_sel[4:3]
    wr_en_key = 6'b000011; wr_data = 32'hBAD0BAD0; slice_sel = 5'd0;
    step();
    wr_en_key = '0;
    chk("wr_err_twohot", wr_err, 1);
    chk("kv_twohot", key_valid, 6'b000001);
    step();
    chk("wr_err_clears", wr_err, 0);
    wr_en_key = 6'b000001; slice_sel = 5'b01000; wr_data = 32'hBAD1BAD1;
    step();
    wr_en_key = '0; slice_sel = '0;
    chk("wr_err_slice", wr_err, 1);
    step();

    // rejected reads: out-of-range slot and empty slot
    rd_req = 1'b1; rd_key_idx = 3'd7;
    step();
    rd_req = 1'b0;
    chk("rd_err_idx7", rd_err, 1);
    chk("valid_idx7", rd_valid, 0);
    step();
    chk("rd_err_pulse", rd_err, 0);
    rd_req = 1'b1; rd_key_idx = 3'd2;
    step();
    rd_req = 1'b0;
    chk("rd_err_slot2", rd_err, 1);
    chk("busy_slot2", rd_busy, 0);
    step();

    // collision: overwrite word5 mid-stream; word0 also proves the illegal writes were dropped
    for (int i = 0; i < 8; i++) exp_q.push_back(i == 5 ? 32'hDEADBEEF : 32'h11111111 * (i + 1));
    run_stream(0, 32'h0, 1'b1, 8, 2, 5, 32'hDEADBEEF);

    // second slot, scattered stalls
    for (int i = 0; i < 8; i++) wr(5, i, 32'hA5000000 | i);
    chk("kv_two_slots", key_valid, 6'b100001);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA5000000 | i);
    run_stream(5, 32'h2A, 1'b0, 11, 0, 0, 32'h0);

    // clear beats a same-cycle write
    key_clear = 6'b000001; wr_en_key = 6'b000001; slice_sel = 5'd3; wr_data = 32'h12345678;
    step();
    key_clear = '0; wr_en_key = '0; slice_sel = '0;
    chk("kv_cleared", key_valid, 6'b100000);
    chk("wr_err_clear", wr_err, 0);
    rd_req = 1'b1; rd_key_idx = 3'd0;
    step();
    rd_req = 1'b0;
    chk("rd_err_cleared", rd_err, 1);

    // async reset mid-stream
    rd_req = 1'b1; rd_key_idx = 3'd5; rd_ready = 1'b1;
    step();
    rd_req = 1'b0;
    chk("mid_valid_pre", rd_valid, 1);
    step();
    step();
    chk("mid_data_pre", rd_data, 32'hA5000002);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_valid", rd_valid, 0);
    chk("abort_data", rd_data, 0);
    chk("abort_last", rd_last, 0);
    chk("abort_busy", rd_busy, 0);
    chk("abort_kv", key_valid, 0);
    step();
    reset_n = 1'b1;
    rd_ready = 1'b0;
    step();
    chk("post_reset_valid", rd_valid, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
